// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB master and slave:
// FSM state type, register offsets and CTRL/STATUS bit positions.
package uart_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  // Register map (byte offsets within the UART APB window)
  localparam logic [9:0] REG_TX_FIFO   = 10'h000;
  localparam logic [9:0] REG_RX_FIFO   = 10'h004;
  localparam logic [9:0] REG_CTRL      = 10'h008;
  localparam logic [9:0] REG_STATUS    = 10'h00C;
  localparam logic [9:0] REG_INTERRUPT = 10'h010;

  // CTRL bit positions
  localparam int unsigned CTRL_TX_EN_BIT  = 0;
  localparam int unsigned CTRL_RX_EN_BIT  = 1;
  localparam int unsigned CTRL_TX_IE_BIT  = 2;
  localparam int unsigned CTRL_RX_IE_BIT  = 3;

  // STATUS bit positions
  localparam int unsigned STATUS_TX_FULL_BIT  = 0;
  localparam int unsigned STATUS_TX_EMPTY_BIT = 1;
  localparam int unsigned STATUS_RX_FULL_BIT  = 2;
  localparam int unsigned STATUS_RX_EMPTY_BIT = 3;

endpackage

// File: rtl/apb_master_timeout_ctr.sv
// ACCESS-phase wait counter for the APB master. Cleared while the
// master is in SETUP, advances on each stalled ACCESS cycle, and flags
// when it has reached TIMEOUT_CYCLES-1.
module apb_master_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic inc,
  output logic limit
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Wait counter; saturates at LAST since the master aborts there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (inc && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign limit = (count == LAST);

endmodule

// File: rtl/apb_uart_master.sv
// APB initiator for the UART slave port: one command at a time on a
// valid/ready request channel, sequenced through SETUP/ACCESS, with the
// result returned on a valid/ready response channel.
// Optional ACCESS timeout: define APB_MASTER_TIMEOUT_EN.
module apb_uart_master
  import uart_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK_i,
  input  logic                    PRESET_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   PADDR_o,
  output logic                    PWRITE_o,
  output logic [DATA_WIDTH-1:0]   PWDATA_o,
  output logic [DATA_WIDTH/8-1:0] PSTRB_o,
  output logic                    PSEL_o,
  output logic                    PENABLE_o,
  input  logic [DATA_WIDTH-1:0]   PRDATA_i,
  input  logic                    PREADY_i,
  input  logic                    PSLVERR_i
);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_t state;

  // Only registered state feeds the request ready
  assign cmd_ready_o = (state == ST_IDLE) && !rsp_valid_o;

`ifdef APB_MASTER_TIMEOUT_EN
  logic ctr_start;
  logic ctr_inc;
  logic ctr_limit;

  assign ctr_start = (state == ST_SETUP);
  assign ctr_inc   = (state == ST_ACCESS) && !PREADY_i;

  apb_master_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk  (PCLK_i),
    .rst  (PRESET_i),
    .start(ctr_start),
    .inc  (ctr_inc),
    .limit(ctr_limit)
  );
`else
  assign rsp_timeout_o = 1'b0;
`endif

  // APB sequencing FSM with registered bus and response outputs
  always_ff @(posedge PCLK_i or posedge PRESET_i) begin
    if (PRESET_i) begin
      state       <= ST_IDLE;
      PADDR_o     <= '0;
      PWRITE_o    <= 1'b0;
      PWDATA_o    <= '0;
      PSTRB_o     <= '0;
      PSEL_o      <= 1'b0;
      PENABLE_o   <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_timeout_o <= 1'b0;
`endif
    end else begin
      // Response consumed; cannot collide with capture, which only
      // happens in ACCESS while no response is pending
      if (rsp_valid_o && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        rsp_timeout_o <= 1'b0;
`endif
      end

      case (state)
        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            PADDR_o  <= cmd_addr_i;
            PWRITE_o <= cmd_write_i;
            PWDATA_o <= cmd_wdata_i;
            PSTRB_o  <= cmd_write_i ? '1 : '0;
            PSEL_o   <= 1'b1;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE_o <= 1'b1;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY_i) begin
            PSEL_o      <= 1'b0;
            PENABLE_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= PWRITE_o ? '0 : PRDATA_i;
            rsp_err_o   <= PSLVERR_i;
            state       <= ST_IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (ctr_limit) begin
            PSEL_o        <= 1'b0;
            PENABLE_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            state         <= ST_IDLE;
          end
`endif
        end
        default: begin
          PSEL_o    <= 1'b0;
          PENABLE_o <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_master.sv
// Bench for apb_uart_master: directed vector table, randomized
// transactions against a transaction-level model, and hand-written
// stall/timeout and reset sequences. Honours APB_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_apb_uart_master;
  import uart_apb_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable, pready, pslverr;
  logic [DW-1:0] pwdata, prdata;
  logic [SW-1:0] pstrb;

  always #5 clk = ~clk;

  apb_uart_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK_i       (clk),
    .PRESET_i     (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_write_i  (cmd_write),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .PADDR_o      (paddr),
    .PWRITE_o     (pwrite),
    .PWDATA_o     (pwdata),
    .PSTRB_o      (pstrb),
    .PSEL_o       (psel),
    .PENABLE_o    (penable),
    .PRDATA_i     (prdata),
    .PREADY_i     (pready),
    .PSLVERR_i    (pslverr)
  );

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int unsigned   waits;
    logic [DW-1:0] prdata;
    logic          slverr;
    int unsigned   hold;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One complete transfer; called at a negedge with the master idle.
  // Cycle numbering: handshake edge is cycle 0, SETUP is cycle 1.
  task automatic run_xfer(input vec_t v);
    logic [31:0] strb_exp;
    strb_exp = v.write ? 32'((1 << SW) - 1) : 32'h0;
    check("idle_cmd_ready", 32'(cmd_ready), 32'h1);
    check("idle_psel", 32'(psel), 32'h0);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    @(negedge clk);
    // scramble the request bus to prove the APB side latched it
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    check("setup_psel", 32'(psel), 32'h1);
    check("setup_penable", 32'(penable), 32'h0);
    check("busy_cmd_ready", 32'(cmd_ready), 32'h0);
    pready = 1'b0;
    for (int unsigned c = 0; c <= v.waits; c++) begin
      @(negedge clk);
      check("access_psel", 32'(psel), 32'h1);
      check("access_penable", 32'(penable), 32'h1);
      check("access_paddr", 32'(paddr), 32'(v.addr));
      check("access_pwrite", 32'(pwrite), 32'(v.write));
      check("access_pwdata", 32'(pwdata), 32'(v.wdata));
      check("access_pstrb", 32'(pstrb), strb_exp);
      check("access_rsp_valid", 32'(rsp_valid), 32'h0);
      if (c == v.waits) begin
        pready  = 1'b1;
        prdata  = v.prdata;
        pslverr = v.slverr;
      end else begin
        pready  = 1'b0;
        prdata  = DW'($urandom);
        pslverr = 1'($urandom);
      end
    end
    @(negedge clk);
    pready  = 1'b0;
    prdata  = DW'($urandom);
    pslverr = 1'($urandom);
    check("done_psel", 32'(psel), 32'h0);
    check("done_penable", 32'(penable), 32'h0);
    check("rsp_valid", 32'(rsp_valid), 32'h1);
    check("rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
    check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    check("rsp_timeout", 32'(rsp_timeout), 32'h0);
    for (int unsigned h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'h1);
      check("hold_rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
      check("hold_rsp_err", 32'(rsp_err), 32'(v.exp_err));
      check("hold_cmd_ready", 32'(cmd_ready), 32'h0);
      check("hold_psel", 32'(psel), 32'h0);
    end
    // keep a pending command asserted across the consume edge
    cmd_valid = (v.hold != 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("consumed_rsp_valid", 32'(rsp_valid), 32'h0);
    check("consumed_rsp_rdata", 32'(rsp_rdata), 32'h0);
    check("no_accept_on_consume", 32'(psel), 32'h0);
    check("consumed_cmd_ready", 32'(cmd_ready), 32'h1);
  endtask

  // Transaction-level expectation: reads return slave data, writes 0;
  // error mirrors the slave's error flag.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_rdata = v.write ? '0 : v.prdata;
    r.exp_err   = v.slverr;
    return r;
  endfunction

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vec_t rv;
    logic [AW-1:0] regs[5];

    regs[0] = REG_TX_FIFO; regs[1] = REG_RX_FIFO; regs[2] = REG_CTRL;
    regs[3] = REG_STATUS;  regs[4] = REG_INTERRUPT;

    //          write addr           wdata  waits    prdata slverr hold exp_rdata exp_err
    vecs[0] = '{1'b1, REG_TX_FIFO,   8'hA5, 0,       8'h77, 1'b0, 0,   8'h00,    1'b0};
    vecs[1] = '{1'b0, REG_RX_FIFO,   8'h00, 3,       8'h3C, 1'b0, 0,   8'h3C,    1'b0};
    vecs[2] = '{1'b0, REG_INTERRUPT + 10'h4, 8'h00, 0, 8'h5A, 1'b1, 0, 8'h5A,    1'b1};
    vecs[3] = '{1'b1, REG_CTRL,      8'h0F, 1,       8'hFF, 1'b0, 5,   8'h00,    1'b0};
    vecs[4] = '{1'b0, REG_STATUS,    8'h00, TO - 1,  8'hC3, 1'b0, 1,   8'hC3,    1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #1;
    check("reset_psel", 32'(psel), 32'h0);
    check("reset_penable", 32'(penable), 32'h0);
    check("reset_paddr", 32'(paddr), 32'h0);
    check("reset_pwrite", 32'(pwrite), 32'h0);
    check("reset_pwdata", 32'(pwdata), 32'h0);
    check("reset_pstrb", 32'(pstrb), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'h0);
    check("reset_rsp_timeout", 32'(rsp_timeout), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_cmd_ready", 32'(cmd_ready), 32'h1);

    for (int unsigned i = 0; i < 5; i++) run_xfer(vecs[i]);

    for (int unsigned i = 0; i < 40; i++) begin
      rv.write  = 1'($urandom);
      rv.addr   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : regs[$urandom_range(0, 4)];
      rv.wdata  = DW'($urandom);
      rv.waits  = $urandom_range(0, 4);
      rv.prdata = DW'($urandom);
      rv.slverr = ($urandom_range(0, 4) == 0);
      rv.hold   = $urandom_range(0, 3);
      run_xfer(model(rv));
    end

    // Slave never ready
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_STATUS; cmd_wdata = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    pready = 1'b0;
    prdata = 8'hE7;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int unsigned c = 0; c < TO; c++) begin
      @(negedge clk);
      check("stall_psel", 32'(psel), 32'h1);
      check("stall_rsp_valid", 32'(rsp_valid), 32'h0);
    end
    @(negedge clk);
    check("timeout_psel", 32'(psel), 32'h0);
    check("timeout_penable", 32'(penable), 32'h0);
    check("timeout_rsp_valid", 32'(rsp_valid), 32'h1);
    check("timeout_rsp_err", 32'(rsp_err), 32'h1);
    check("timeout_rsp_timeout", 32'(rsp_timeout), 32'h1);
    check("timeout_rsp_rdata", 32'(rsp_rdata), 32'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("timeout_consumed", 32'(rsp_valid), 32'h0);
    check("timeout_flag_cleared", 32'(rsp_timeout), 32'h0);
`else
    repeat (100) @(negedge clk);
    check("stuck_psel", 32'(psel), 32'h1);
    check("stuck_penable", 32'(penable), 32'h1);
    check("stuck_rsp_valid", 32'(rsp_valid), 32'h0);
    check("stuck_rsp_timeout", 32'(rsp_timeout), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    // Reset pulse in the middle of ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_RX_FIFO; cmd_wdata = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    pready = 1'b0;
    @(negedge clk);
    check("pre_reset_penable", 32'(penable), 32'h1);
    rst = 1'b1;
    #1;
    check("async_reset_psel", 32'(psel), 32'h0);
    check("async_reset_penable", 32'(penable), 32'h0);
    check("async_reset_rsp_valid", 32'(rsp_valid), 32'h0);
    pready = 1'b1;
    prdata = 8'h99;
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk);
      check("after_reset_rsp_valid", 32'(rsp_valid), 32'h0);
      check("after_reset_psel", 32'(psel), 32'h0);
      check("after_reset_cmd_ready", 32'(cmd_ready), 32'h1);
    end
    pready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_uart_master.md
# apb_uart_master

APB initiator that drives register transactions into the UART's APB slave port: TX/RX FIFO data, CTRL, STATUS and INTERRUPT registers. It accepts one command at a time on a valid/ready request channel and sequences it through the APB SETUP and ACCESS phases. It returns read data and error status on a valid/ready response channel. It sits between a local controller (CPU shim, test sequencer or bridge) and the UART's APB slave port.

## Interface
- ADDR_WIDTH, 10, APB address width (matches 1024-deep slave decode)
- DATA_WIDTH, 8, APB data width; multiple of 8
- TIMEOUT_CYCLES, 16, max ACCESS cycles before abort (used only with timeout feature)

- PCLK_i  in  1  clock, rising edge
- PRESET_i  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  request valid
- cmd_ready_o  out  1  request accepted when high with cmd_valid_i
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_WIDTH  target address
- cmd_wdata_i  in  DATA_WIDTH  write data
- rsp_valid_o  out  1  response valid, held until consumed
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes/aborts
- rsp_err_o  out  1  PSLVERR or timeout
- rsp_timeout_o  out  1  transfer aborted by timeout
- PADDR_o  out  ADDR_WIDTH  APB address
- PWRITE_o  out  1  APB direction
- PWDATA_o  out  DATA_WIDTH  APB write data
- PSTRB_o  out  DATA_WIDTH/8  all ones on write, 0 on read
- PSEL_o  out  1  APB select
- PENABLE_o  out  1  APB enable
- PRDATA_i  in  DATA_WIDTH  APB read data
- PREADY_i  in  1  APB ready
- PSLVERR_i  in  1  APB slave error

## Operation
- FSM states and transitions:
  - IDLE: PSEL_o=0, PENABLE_o=0. On cmd handshake, latch addr, write, wdata and strobe into APB output registers, then go to SETUP.
  - SETUP: PSEL_o=1, PENABLE_o=0; unconditionally go to ACCESS.
  - ACCESS: PSEL_o=1, PENABLE_o=1. While PREADY_i=0, hold all APB outputs stable. On PREADY_i=1, capture the response and return to IDLE.
- Response capture on completion:
  - rsp_rdata_o = PRDATA_i for reads, 0 for writes.
  - rsp_err_o = PSLVERR_i.
  - rsp_valid_o = 1.
- Back-to-back transfers always pass through IDLE: at least one PSEL_o-low cycle between transfers.
- Response hold: rsp_valid_o and its data stay stable until the rsp handshake, then clear.
- Request acceptance: cmd_ready_o = (state==IDLE) && !rsp_valid_o, a combinational function of registered state only. A new command is never accepted in the same cycle a response is consumed.
- Reset values: state IDLE; all registered outputs 0 (PADDR_o, PWRITE_o, PWDATA_o, PSTRB_o, PSEL_o, PENABLE_o, rsp_*). cmd_ready_o therefore reads 1 while reset is deasserted and idle.
- Reset mid-transfer: PSEL_o and PENABLE_o drop immediately (asynchronously); any in-flight or pending response is discarded.

## Timing
- Cycle 0 is the cmd handshake edge.
- Cycle 1: SETUP. Cycle 2: ACCESS.
- If PREADY_i=1 at cycle 2, rsp_valid_o=1 from cycle 3.
- Each PREADY_i=0 wait cycle adds one cycle of latency.
- PSLVERR_i and PRDATA_i are sampled only on the edge where PENABLE_o && PREADY_i.
- No combinational path from APB inputs to any output.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: a counter starts at 0 on entry to ACCESS and increments each ACCESS cycle with PREADY_i=0.
  - When it reaches TIMEOUT_CYCLES-1 with PREADY_i still 0, the transfer aborts:
    - return to IDLE, PSEL_o and PENABLE_o deasserted;
    - rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
  - PREADY_i=1 on that same cycle counts as normal completion, not a timeout.
- Undefined: ACCESS waits indefinitely; rsp_timeout_o is constant 0; the counter is absent.

## Structure
- Shared package uart_apb_pkg holds:
  - FSM state typedef (IDLE/SETUP/ACCESS, 2-bit);
  - register offset constants TX_FIFO 0x00, RX_FIFO 0x04, CTRL 0x08, STATUS 0x0C, INTERRUPT 0x10;
  - CTRL/STATUS bit-field position constants, shared with the slave.
- One sub-module, apb_master_timeout_ctr: the ACCESS-cycle counter. It is instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write 0xA5 to 0x000, PREADY_i tied 1:
  - PSEL_o rises cycle 1, PENABLE_o cycle 2;
  - rsp_valid_o cycle 3 with rsp_err_o=0, rsp_rdata_o=0x00;
  - PSTRB_o=1.
- Read 0x004, PREADY_i low for 3 ACCESS cycles, PRDATA_i=0x3C at completion:
  - APB outputs are stable through the waits;
  - rsp_valid_o at cycle 6 with rsp_rdata_o=0x3C.
- Read 0x014, slave returns PSLVERR_i=1 with PREADY_i=1 -> rsp_err_o=1, rsp_timeout_o=0.
- rsp_ready_i held 0 for 5 cycles after a response while cmd_valid_i=1:
  - cmd_ready_o stays 0 and no PSEL_o activity occurs;
  - after the rsp handshake the next command is accepted and PSEL_o returns after at least one idle cycle.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY_i stuck 0:
  - abort after 16 ACCESS cycles;
  - rsp_err_o=1, rsp_timeout_o=1, PSEL_o=0.
  - Without the macro, the bench still waits after 100 cycles with PSEL_o=1.
- PRESET_i pulsed during ACCESS -> PSEL_o and PENABLE_o drop before the next clock edge, no response is produced, and cmd_ready_o=1 after reset release.
